// File: rtl/lcd_cmd_decoder_if.sv
// Byte write bus from the display command sequencer to the command decoder.
// Latency: none (wires only); the slave samples D/dcx on a clk edge with wr_en=1.
// Backpressure: none; there is no ready, every strobed byte is taken by the slave.
interface lcd_cmd_decoder_if;
  logic       wr_en;
  logic [7:0] D;
  logic       dcx;

  modport master (output wr_en, output D, output dcx);
  modport slave  (input  wr_en, input  D, input  dcx);
endinterface

// File: rtl/lcd_cmd_decoder.sv
// Display-controller receive model: decodes SWRESET/SLPOUT/DISPON/DISPOFF/CASET/PASET/RAMWR/NOP into pixel writes.
// Latency: every response (pix_we, flags, cmd_err) is registered and appears one cycle after the accepted byte.
// Backpressure: none; bytes arriving during the post-reset/sleep-out wait are dropped and flagged on cmd_err.
module lcd_cmd_decoder #(
  parameter int COLS           = 240,
  parameter int ROWS           = 320,
  parameter int WAIT_CYCLES    = 50000,
  parameter bit LOW_BYTE_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                nrst,
  lcd_cmd_decoder_if.slave    bus,
  output logic                pix_we,
  output logic [15:0]         pix_x,
  output logic [15:0]         pix_y,
  output logic [15:0]         pix_color,
  output logic                disp_on,
  output logic                awake,
  output logic                busy,
  output logic                cmd_err
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

  localparam logic [7:0] CMD_NOP     = 8'h00;
  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_DISPOFF = 8'h28;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_PASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  localparam logic [15:0] EC_DEF = 16'(COLS - 1);
  localparam logic [15:0] EP_DEF = 16'(ROWS - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CASET_P  = 3'd1,
    PASET_P  = 3'd2,
    RAMWR_LO = 3'd3,
    RAMWR_HI = 3'd4,
    WAIT     = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    pidx_q, pidx_d;
  logic [23:0]   param_q, param_d;     // first three window parameter bytes
  logic [15:0]   sc_q, sc_d, ec_q, ec_d;
  logic [15:0]   sp_q, sp_d, ep_q, ep_d;
  logic [15:0]   cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [7:0]    first_q, first_d;     // first byte of a pixel in flight
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pix_we_q, pix_we_d;
  logic [15:0]   pix_x_q, pix_x_d, pix_y_q, pix_y_d, pix_color_q, pix_color_d;
  logic          disp_on_q, disp_on_d, awake_q, awake_d, busy_q, busy_d;
  logic          cmd_err_q, cmd_err_d;

  logic [15:0]   p_start, p_end;

  // The 4th parameter byte completes the end coordinate; start is already buffered.
  assign p_start = param_q[23:8];
  assign p_end   = {param_q[7:0], bus.D};

  // Next-state and output decode for one accepted byte (or wait-counter tick).
  always_comb begin
    state_d     = state_q;
    pidx_d      = pidx_q;
    param_d     = param_q;
    sc_d        = sc_q;
    ec_d        = ec_q;
    sp_d        = sp_q;
    ep_d        = ep_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    first_d     = first_q;
    cnt_d       = cnt_q;
    pix_we_d    = 1'b0;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_color_d = pix_color_q;
    disp_on_d   = disp_on_q;
    awake_d     = awake_q;
    busy_d      = busy_q;
    cmd_err_d   = 1'b0;

    if (state_q == WAIT) begin
      // Counter runs regardless of traffic; stray bytes never restart it.
      if (cnt_q == '0) begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      if (bus.wr_en) cmd_err_d = 1'b1;
    end else if (bus.wr_en && !bus.dcx) begin
      // A command always aborts any partial parameter set or half pixel.
      case (bus.D)
        CMD_SWRESET: begin
          sc_d      = '0;
          ec_d      = EC_DEF;
          sp_d      = '0;
          ep_d      = EP_DEF;
          disp_on_d = 1'b0;
          awake_d   = 1'b0;
          busy_d    = 1'b1;
          cnt_d     = CW'(WAIT_CYCLES - 1);
          state_d   = WAIT;
        end
        CMD_SLPOUT: begin
          awake_d = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = CW'(WAIT_CYCLES - 1);
          state_d = WAIT;
        end
        CMD_DISPOFF: begin
          disp_on_d = 1'b0;
          state_d   = IDLE;
        end
        CMD_DISPON: begin
          disp_on_d = 1'b1;
          state_d   = IDLE;
        end
        CMD_CASET: begin
          pidx_d  = 2'd0;
          state_d = CASET_P;
        end
        CMD_PASET: begin
          pidx_d  = 2'd0;
          state_d = PASET_P;
        end
        CMD_RAMWR: begin
          cur_x_d = sc_q;
          cur_y_d = sp_q;
          state_d = RAMWR_LO;
        end
        CMD_NOP: begin
          state_d = IDLE;
        end
        default: begin
          cmd_err_d = 1'b1;
          state_d   = IDLE;
        end
      endcase
    end else if (bus.wr_en) begin
      case (state_q)
        CASET_P, PASET_P: begin
          pidx_d = pidx_q + 2'd1;
          case (pidx_q)
            2'd0: param_d[23:16] = bus.D;
            2'd1: param_d[15:8]  = bus.D;
            2'd2: param_d[7:0]   = bus.D;
            default: begin
              // An inverted window is rejected whole; the old window stays.
              if (p_start <= p_end) begin
                if (state_q == CASET_P) begin
                  sc_d = p_start;
                  ec_d = p_end;
                end else begin
                  sp_d = p_start;
                  ep_d = p_end;
                end
              end else begin
                cmd_err_d = 1'b1;
              end
              state_d = IDLE;
            end
          endcase
        end
        RAMWR_LO: begin
          first_d = bus.D;
          state_d = RAMWR_HI;
        end
        RAMWR_HI: begin
          pix_we_d    = 1'b1;
          pix_x_d     = cur_x_q;
          pix_y_d     = cur_y_q;
          pix_color_d = LOW_BYTE_FIRST ? {bus.D, first_q} : {first_q, bus.D};
          // Raster advance inside the window; y wraps back to the window origin.
          if (cur_x_q == ec_q) begin
            cur_x_d = sc_q;
            cur_y_d = (cur_y_q == ep_q) ? sp_q : cur_y_q + 16'd1;
          end else begin
            cur_x_d = cur_x_q + 16'd1;
          end
          state_d = RAMWR_LO;
        end
        default: begin
          // Data with no command expecting it.
          cmd_err_d = 1'b1;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= IDLE;
      pidx_q      <= 2'd0;
      param_q     <= '0;
      sc_q        <= '0;
      ec_q        <= EC_DEF;
      sp_q        <= '0;
      ep_q        <= EP_DEF;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      first_q     <= '0;
      cnt_q       <= '0;
      pix_we_q    <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_color_q <= '0;
      disp_on_q   <= 1'b0;
      awake_q     <= 1'b0;
      busy_q      <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pidx_q      <= pidx_d;
      param_q     <= param_d;
      sc_q        <= sc_d;
      ec_q        <= ec_d;
      sp_q        <= sp_d;
      ep_q        <= ep_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      first_q     <= first_d;
      cnt_q       <= cnt_d;
      pix_we_q    <= pix_we_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_color_q <= pix_color_d;
      disp_on_q   <= disp_on_d;
      awake_q     <= awake_d;
      busy_q      <= busy_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  assign pix_we    = pix_we_q;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign pix_color = pix_color_q;
  assign disp_on   = disp_on_q;
  assign awake     = awake_q;
  assign busy      = busy_q;
  assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_lcd_cmd_decoder.sv
// Self-checking bench for lcd_cmd_decoder: vector table plus hand-written wait/reset/window sequences.
// Latency: expects each response one cycle after the byte strobe.
// Backpressure: none; bytes are strobed one per cycle at most.
module tb_lcd_cmd_decoder;

  localparam int W = 20;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        pix_we, disp_on, awake, busy, cmd_err;
  logic [15:0] pix_x, pix_y, pix_color;

  int total = 0;
  int bad   = 0;

  lcd_cmd_decoder_if bus_if ();

  lcd_cmd_decoder #(
    .COLS(240), .ROWS(320), .WAIT_CYCLES(W), .LOW_BYTE_FIRST(1'b1)
  ) dut (
    .clk(clk), .nrst(nrst), .bus(bus_if.slave),
    .pix_we(pix_we), .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
    .disp_on(disp_on), .awake(awake), .busy(busy), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        dcx;
    logic [7:0]  d;
    logic        we;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] c;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one bus cycle at the falling edge; return #1 after the sampling edge.
  task automatic send(input logic w, input logic c, input logic [7:0] d);
    @(negedge clk);
    bus_if.wr_en = w;
    bus_if.dcx   = c;
    bus_if.D     = d;
    @(posedge clk);
    #1;
    bus_if.wr_en = 1'b0;
  endtask

  task automatic pix(input logic [15:0] col);
    send(1'b1, 1'b1, col[7:0]);
    send(1'b1, 1'b1, col[15:8]);
  endtask

  task automatic add(input logic w, input logic c, input logic [7:0] d, input logic we,
                     input logic [15:0] x, input logic [15:0] y, input logic [15:0] col,
                     input logic err);
    vec_t v;
    v.wr = w; v.dcx = c; v.d = d; v.we = we; v.x = x; v.y = y; v.c = col; v.err = err;
    vecs.push_back(v);
  endtask

  task automatic cmd(input logic [7:0] d, input logic err);
    add(1'b1, 1'b0, d, 1'b0, 16'h0, 16'h0, 16'h0, err);
  endtask

  task automatic dat(input logic [7:0] d, input logic err);
    add(1'b1, 1'b1, d, 1'b0, 16'h0, 16'h0, 16'h0, err);
  endtask

  task automatic datpix(input logic [7:0] d, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] col);
    add(1'b1, 1'b1, d, 1'b1, x, y, col, 1'b0);
  endtask

  int n;

  initial begin
    bus_if.wr_en = 1'b0;
    bus_if.dcx   = 1'b0;
    bus_if.D     = 8'h00;

    // ---- table: window setup, pixels, wraps, errors, aborts ----
    cmd(8'h2A, 0); dat(8'h00, 0); dat(8'h14, 0); dat(8'h00, 0); dat(8'h28, 0);
    cmd(8'h2B, 0); dat(8'h00, 0); dat(8'h3C, 0); dat(8'h00, 0); dat(8'h50, 0);
    cmd(8'h2C, 0); dat(8'h1E, 0); datpix(8'h90, 16'd20, 16'd60, 16'h901E);
    // window 20..22 x 60..61, seven pixels wrap x and y
    cmd(8'h2A, 0); dat(8'h00, 0); dat(8'h14, 0); dat(8'h00, 0); dat(8'h16, 0);
    dat(8'h99, 1);  // data in IDLE after a complete parameter set
    cmd(8'h2B, 0); dat(8'h00, 0); dat(8'h3C, 0); dat(8'h00, 0); dat(8'h3D, 0);
    cmd(8'h2C, 0);
    dat(8'h00, 0); datpix(8'h10, 16'd20, 16'd60, 16'h1000);
    dat(8'h01, 0); datpix(8'h11, 16'd21, 16'd60, 16'h1101);
    dat(8'h02, 0); datpix(8'h12, 16'd22, 16'd60, 16'h1202);
    dat(8'h03, 0); datpix(8'h13, 16'd20, 16'd61, 16'h1303);
    dat(8'h04, 0); datpix(8'h14, 16'd21, 16'd61, 16'h1404);
    dat(8'h05, 0); datpix(8'h15, 16'd22, 16'd61, 16'h1505);
    dat(8'h06, 0); datpix(8'h16, 16'd20, 16'd60, 16'h1606);
    // strobe low: ignored even though it looks like an unknown command
    add(1'b0, 1'b0, 8'h36, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    // inverted CASET rejected, window kept
    cmd(8'h2A, 0); dat(8'h00, 0); dat(8'h28, 0); dat(8'h00, 0); dat(8'h14, 1);
    cmd(8'h2C, 0); dat(8'h01, 0); datpix(8'h02, 16'd20, 16'd60, 16'h0201);
    // partial CASET aborted by RAMWR, window kept
    cmd(8'h2A, 0); dat(8'h00, 0); dat(8'h05, 0);
    cmd(8'h2C, 0); dat(8'hAA, 0); datpix(8'hBB, 16'd20, 16'd60, 16'hBBAA);
    // half pixel discarded by NOP
    cmd(8'h2C, 0); dat(8'h55, 0); cmd(8'h00, 0);
    cmd(8'h2C, 0); dat(8'h33, 0); datpix(8'h44, 16'd20, 16'd60, 16'h4433);
    // unknown command, then data in IDLE
    cmd(8'h36, 1); dat(8'h77, 1);

    // ---- reset state ----
    repeat (3) send(1'b0, 1'b0, 8'h00);
    chk("rst_pix_we", 32'(pix_we), 32'd0);
    chk("rst_cmd_err", 32'(cmd_err), 32'd0);
    chk("rst_disp_on", 32'(disp_on), 32'd0);
    chk("rst_awake", 32'(awake), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pix_x", 32'(pix_x), 32'd0);
    chk("rst_pix_y", 32'(pix_y), 32'd0);
    chk("rst_pix_color", 32'(pix_color), 32'd0);
    @(negedge clk);
    nrst = 1'b1;

    // ---- SWRESET wait, with DISPON and SWRESET dropped mid-wait ----
    send(1'b1, 1'b0, 8'h01);
    n = 0;
    while (busy === 1'b1 && n < 4 * W) begin
      n++;
      if (n == 3) begin
        send(1'b1, 1'b0, 8'h29);
        chk("wait_dispon_err", 32'(cmd_err), 32'd1);
        chk("wait_dispon_off", 32'(disp_on), 32'd0);
      end else if (n == 6) begin
        send(1'b1, 1'b0, 8'h01);
        chk("wait_swreset_err", 32'(cmd_err), 32'd1);
      end else begin
        send(1'b0, 1'b0, 8'h00);
      end
    end
    chk("swreset_busy_cycles", 32'(n), 32'(W));
    chk("swreset_disp_on", 32'(disp_on), 32'd0);
    chk("swreset_awake", 32'(awake), 32'd0);

    // ---- SLPOUT wait ----
    send(1'b1, 1'b0, 8'h11);
    chk("slpout_awake", 32'(awake), 32'd1);
    n = 0;
    while (busy === 1'b1 && n < 4 * W) begin
      n++;
      send(1'b0, 1'b0, 8'h00);
    end
    chk("slpout_busy_cycles", 32'(n), 32'(W));
    send(1'b1, 1'b0, 8'h29);
    chk("dispon", 32'(disp_on), 32'd1);
    chk("dispon_err", 32'(cmd_err), 32'd0);

    // ---- table ----
    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i].wr, vecs[i].dcx, vecs[i].d);
      chk($sformatf("v%0d_pix_we", i), 32'(pix_we), 32'(vecs[i].we));
      chk($sformatf("v%0d_cmd_err", i), 32'(cmd_err), 32'(vecs[i].err));
      chk($sformatf("v%0d_disp_on", i), 32'(disp_on), 32'd1);
      if (vecs[i].we) begin
        chk($sformatf("v%0d_x", i), 32'(pix_x), 32'(vecs[i].x));
        chk($sformatf("v%0d_y", i), 32'(pix_y), 32'(vecs[i].y));
        chk($sformatf("v%0d_color", i), 32'(pix_color), 32'(vecs[i].c));
      end
    end

    // ---- reset mid-CASET restores defaults ----
    send(1'b1, 1'b0, 8'h2A);
    send(1'b1, 1'b1, 8'h00);
    send(1'b1, 1'b1, 8'h28);
    @(negedge clk);
    nrst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_disp_on", 32'(disp_on), 32'd0);
    chk("midrst_awake", 32'(awake), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    send(1'b1, 1'b1, 8'h00);
    chk("midrst_idle_data_err", 32'(cmd_err), 32'd1);

    // default column window 0..239
    send(1'b1, 1'b0, 8'h2C);
    for (int p = 0; p <= 240; p++) begin
      pix(16'(p));
      if (p == 0 || p == 239 || p == 240) begin
        chk($sformatf("defx_p%0d_we", p), 32'(pix_we), 32'd1);
        chk($sformatf("defx_p%0d_x", p), 32'(pix_x), (p == 240) ? 32'd0 : 32'(p));
        chk($sformatf("defx_p%0d_y", p), 32'(pix_y), (p == 240) ? 32'd1 : 32'd0);
        chk($sformatf("defx_p%0d_c", p), 32'(pix_color), 32'(p));
      end
    end

    // single-column window exposes the default page end 319
    send(1'b1, 1'b0, 8'h2A);
    send(1'b1, 1'b1, 8'h00);
    send(1'b1, 1'b1, 8'h00);
    send(1'b1, 1'b1, 8'h00);
    send(1'b1, 1'b1, 8'h00);
    chk("col0_caset_err", 32'(cmd_err), 32'd0);
    send(1'b1, 1'b0, 8'h2C);
    for (int p = 0; p <= 320; p++) begin
      pix(16'h8000 + 16'(p));
      if (p == 0 || p == 319 || p == 320) begin
        chk($sformatf("defy_p%0d_x", p), 32'(pix_x), 32'd0);
        chk($sformatf("defy_p%0d_y", p), 32'(pix_y), (p == 320) ? 32'd0 : 32'(p));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
